trade_engine_multi: RTL

- Parametrised successor to the single-stream buy/sell engine behind the Ethernet/soft-processor bridge.
- Accepts price samples tagged with a stock id over a valid/ready handshake and keeps per-stock last price, position and entry price.
- Emits buy/sell events over a second valid/ready handshake and accumulates signed realized profit.
- Sits between the processor's GPIO/stream output and the result GPIO back to the processor.

---
 rtl/trade_engine_multi.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/trade_engine_multi.sv
// trade_engine_multi: per-stock buy/sell engine fed by id-tagged price samples.
// Optional macro TRADE_STOP_LOSS_EN adds a STOP_DROP stop-loss sell rule.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_stock_id/in_price
//   sample stream; out_valid/out_ready/out_buy/out_sell/out_stock_id/out_price
//   trade stream; profit (signed, saturating), holding (per-stock position),
//   trade_count (wrapping event count), drop_pulse (invalid id consumed).
module trade_engine_multi #(
    parameter int NUM_STOCKS = 4,
    parameter int PRICE_W = 16,
    parameter int PROFIT_W = 24,
    parameter logic [PRICE_W-1:0] BUY_DROP = 16'd8,
    parameter logic [PRICE_W-1:0] SELL_RISE = 16'd8,
`ifdef TRADE_STOP_LOSS_EN
    parameter logic [PRICE_W-1:0] STOP_DROP = 16'd16,
`endif
    localparam int ID_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ID_W-1:0]            in_stock_id,
    input  logic [PRICE_W-1:0]         in_price,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_buy,
    output logic                       out_sell,
    output logic [ID_W-1:0]            out_stock_id,
    output logic [PRICE_W-1:0]         out_price,
    output logic signed [PROFIT_W-1:0] profit,
    output logic [NUM_STOCKS-1:0]      holding,
    output logic [15:0]                trade_count,
    output logic                       drop_pulse
);

    // Storage covers every encodable id so reads never go out of range.
    localparam int DEPTH = 1 << ID_W;
    localparam int PW1 = PRICE_W + 1;
    localparam int FW1 = PROFIT_W + 1;

    typedef enum logic [1:0] {IDLE, EVAL, EMIT} state_t;

    state_t state, state_nx;

    logic [ID_W-1:0]    lat_id;
    logic [PRICE_W-1:0] lat_price;
    logic [PRICE_W-1:0] last_price [DEPTH];
    logic [PRICE_W-1:0] buy_price [DEPTH];
    logic [DEPTH-1:0]   has_last;
    logic [DEPTH-1:0]   held;
    logic               evt_buy;

    logic                id_ok;
    logic                do_buy;
    logic                do_sell;
    logic                do_stop;
    logic                do_exit;
    logic [PW1-1:0]      lp;
    logic [PW1-1:0]      pr;
    logic [PW1-1:0]      bp;
    logic [PW1-1:0]      delta;
    logic [FW1-1:0]      delta_x;
    logic [FW1-1:0]      sum;
    logic [PROFIT_W-1:0] profit_nx;

    assign id_ok   = int'(lat_id) < NUM_STOCKS;
    assign holding = held[NUM_STOCKS-1:0];
    assign out_buy  = out_valid & evt_buy;
    assign out_sell = out_valid & ~evt_buy;

    // Decision datapath; compares run one bit wider than prices.
    always_comb begin
        lp = {1'b0, last_price[lat_id]};
        pr = {1'b0, lat_price};
        bp = {1'b0, buy_price[lat_id]};
        do_buy  = 1'b0;
        do_sell = 1'b0;
        do_stop = 1'b0;
        if (state == EVAL && id_ok && has_last[lat_id]) begin
            do_buy  = !held[lat_id] && lp >= pr
                      && (lp - pr) >= {1'b0, BUY_DROP};
            do_sell = held[lat_id]
                      && pr >= bp + {1'b0, SELL_RISE};
`ifdef TRADE_STOP_LOSS_EN
            do_stop = held[lat_id] && bp >= pr
                      && (bp - pr) >= {1'b0, STOP_DROP};
`endif
        end
        do_exit = do_sell | do_stop;

        // Gain and stop-loss both reduce to price - entry as a signed value.
        delta   = pr - bp;
        delta_x = {{(FW1 - PW1){delta[PRICE_W]}}, delta};
        sum     = {profit[PROFIT_W-1], profit} + delta_x;
        if (sum[PROFIT_W] != sum[PROFIT_W-1]) begin
            profit_nx = sum[PROFIT_W]
                      ? {1'b1, {(PROFIT_W-1){1'b0}}}
                      : {1'b0, {(PROFIT_W-1){1'b1}}};
        end else begin
            profit_nx = sum[PROFIT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        drop_pulse = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) state_nx = EVAL;
            end
            EVAL: begin
                drop_pulse = !id_ok;
                state_nx   = (do_buy || do_exit) ? EMIT : IDLE;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_id       <= '0;
            lat_price    <= '0;
            has_last     <= '0;
            held         <= '0;
            evt_buy      <= 1'b0;
            out_stock_id <= '0;
            out_price    <= '0;
            profit       <= '0;
            trade_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                last_price[i] <= '0;
                buy_price[i]  <= '0;
            end
        end else begin
            if (state == IDLE && in_valid) begin
                lat_id    <= in_stock_id;
                lat_price <= in_price;
            end
            if (state == EVAL && id_ok) begin
                last_price[lat_id] <= lat_price;
                has_last[lat_id]   <= 1'b1;
                if (do_buy) begin
                    held[lat_id]      <= 1'b1;
                    buy_price[lat_id] <= lat_price;
                end
                if (do_exit) begin
                    held[lat_id] <= 1'b0;
                    profit       <= profit_nx;
                end
                if (do_buy || do_exit) begin
                    evt_buy      <= do_buy;
                    out_stock_id <= lat_id;
                    out_price    <= lat_price;
                end
            end
            if (out_valid && out_ready) trade_count <= trade_count + 16'd1;
        end
    end

endmodule
